softmax_sub_ctrl: RTL and testbench

Sequencer that feeds the softmax stage's shared IEEE-754 single-precision subtractor. It accepts one vector of N logits, tracks their running maximum while loading, then streams `x[i] - max` for every element through the external subtractor to the exponent stage. It sits between the final dense-layer output buffer and the softmax exponent unit, and owns the subtractor's operand inputs exclusively while busy.

---
 rtl/softmax_pkg.sv | 23 ++
 rtl/fp32_gt.sv | 22 ++
 rtl/softmax_sub_ctrl.sv | 128 ++++++++++++
 tb/tb_softmax_sub_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax subtractor sequencer.
// The optional clamp helper is used when SOFTMAX_SUB_CLAMP_EN is defined.
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUB,
        ST_DONE
    } state_t;

    localparam int          N_CLASSES_DEF = 10;
    localparam logic [31:0] FP_NEG16      = 32'hC1800000;
    localparam logic [7:0]  FP_CLAMP_EXP  = 8'h83;

    // Negative differences of magnitude 16 or more saturate to -16.
    function automatic logic [31:0] clamp_diff(input logic [31:0] d);
        if (d[31] && (d[30:23] >= FP_CLAMP_EXP))
            return FP_NEG16;
        return d;
    endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict greater-than for FP32 values in sign-magnitude order.
// +0 and -0 compare equal; NaN/Inf are ordered by their raw bits.
module fp32_gt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        gt = 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            gt = 1'b0;
        else if (a[31] != b[31])
            gt = ~a[31];
        else if (!a[31])
            gt = (a[30:0] > b[30:0]);
        else
            gt = (a[30:0] < b[30:0]);
    end

endmodule

// File: rtl/softmax_sub_ctrl.sv
// Loads a vector of FP32 logits, tracks the running maximum, then streams x[i]-max
// through the external subtractor. Optional saturation: define SOFTMAX_SUB_CLAMP_EN.
module softmax_sub_ctrl
    import softmax_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      sub_a,
    output logic [31:0]      sub_b,
    input  logic [31:0]      sub_res,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [31:0]      max_out,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      buf_mem [N_CLASSES];
    logic [31:0]      max_q;
    logic             issued_all;
    logic             in_gt_max;
    logic             load_beat, last_beat;
    logic             capture, final_accept;
    logic [31:0]      diff;

    fp32_gt u_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (in_gt_max)
    );

    assign in_ready     = (state == ST_LOAD);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign max_out      = max_q;

    assign load_beat    = in_valid & in_ready;
    assign last_beat    = load_beat && (cnt == LAST_IDX);
    assign capture      = (state == ST_SUB) && !issued_all && (!out_valid || out_ready);
    assign final_accept = (state == ST_SUB) && issued_all && out_valid && out_ready;

    assign sub_a = (state == ST_SUB) ? buf_mem[cnt] : 32'd0;
    assign sub_b = (state == ST_SUB) ? max_q        : 32'd0;

`ifdef SOFTMAX_SUB_CLAMP_EN
    assign diff = clamp_diff(sub_res);
`else
    assign diff = sub_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)        state_nxt = ST_LOAD;
            ST_LOAD: if (last_beat)    state_nxt = ST_SUB;
            ST_SUB:  if (final_accept) state_nxt = ST_DONE;
            ST_DONE:                   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Element store: written only during LOAD, read back during SUB.
    always_ff @(posedge clk) begin
        // NOTE: the element buffer is deliberately not reset; every entry is written before it is read.
        if (load_beat)
            buf_mem[cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            issued_all <= 1'b0;
            max_q      <= 32'd0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                cnt        <= '0;
                issued_all <= 1'b0;
            end else if (load_beat) begin
                cnt <= last_beat ? '0 : cnt + IDX_W'(1);
            end else if (capture) begin
                // cnt parks on the last index so the operands stay in range.
                if (cnt == LAST_IDX)
                    issued_all <= 1'b1;
                else
                    cnt <= cnt + IDX_W'(1);
            end

            if (load_beat && ((cnt == '0) || in_gt_max))
                max_q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_idx   <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= diff;
            out_idx   <= cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_softmax_sub_ctrl.sv
// Randomized self-checking bench for softmax_sub_ctrl with a real-arithmetic reference model.
// Also provides the combinational FP32 subtractor the block expects to be wired to.
module tb_softmax_sub_ctrl;

    localparam int N     = 3;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      sub_a, sub_b, sub_res;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic [31:0]      max_out;
    logic             busy;
    logic             done;

    softmax_sub_ctrl #(.N_CLASSES(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_res   (sub_res),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .max_out   (max_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FP32 <-> real conversions for normal numbers and signed zero.
    function automatic real fp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0)
            d = {f[31], 63'd0};
        else
            d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        logic        g, s;
        d = $realtobits(r);
        if (d[62:0] == 63'd0)
            return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        g = d[28];
        s = |d[27:0];
        if (g && (s || m[0]))
            m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) - fp_to_real(b));
    endfunction

    function automatic logic [31:0] model_clamp(input logic [31:0] d);
`ifdef SOFTMAX_SUB_CLAMP_EN
        if (d[31] && (d[30:23] >= 8'h83))
            return 32'hC1800000;
`endif
        return d;
    endfunction

    always_comb sub_res = fsub(sub_a, sub_b);

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_max;
    logic [31:0] got_data [N];
    logic [31:0] got_max;
    int          done_cnt;
    int          tests;
    int          fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd0);
            check("rst_out_data",  out_data,       32'd0);
            check("rst_max_out",   max_out,        32'd0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("out_idx",  32'(out_idx), 32'(exp_q[0].idx));
                    check("out_data", out_data,     exp_q[0].data);
                    check("max_out",  max_out,      exp_max);
                    if (out_ready) begin
                        if (int'(out_idx) < N)
                            got_data[out_idx] = out_data;
                        got_max = max_out;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                check("done_all_outputs", 32'(exp_q.size()), 32'd0);
                done_cnt++;
            end
            if (!busy) begin
                check("idle_sub_a", sub_a, 32'd0);
                check("idle_sub_b", sub_b, 32'd0);
            end
        end
    end

    // mode 0: out_ready=1, no gaps; 1: 3-cycle stall at index 1; 2: random gaps and ready.
    task automatic send_vector(input logic [31:0] v [N], input int mode, input bit poke_start);
        int mi, edges, stall_cnt, cyc, done_before;
        bit seen;
        mi = 0;
        for (int i = 1; i < N; i++)
            if (fp_to_real(v[i]) > fp_to_real(v[mi]))
                mi = i;
        exp_max = v[mi];
        for (int i = 0; i < N; i++)
            exp_q.push_back('{idx: i, data: model_clamp(fsub(v[i], v[mi]))});
        done_before = done_cnt;

        check("in_ready_before_start", 32'(in_ready), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        check("in_ready_after_start", 32'(in_ready), 32'd1);

        for (int i = 0; i < N; i++) begin
            if (mode == 2) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    edges++;
                end
            end
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #1;
            edges++;
        end

        stall_cnt = 0;
        cyc       = 0;
        seen      = 1'b0;
        while (!seen && cyc < 200) begin
            in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = $urandom;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = !(out_valid && (out_idx == IDX_W'(1)) && (stall_cnt < 3));
                    if (!out_ready)
                        stall_cnt++;
                end
                default: out_ready = 1'($urandom_range(0, 3) != 0);
            endcase
            start = poke_start && (cyc == 1);
            @(posedge clk); #1;
            edges++;
            cyc++;
            if (done)
                seen = 1'b1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        check("done_seen", 32'(seen), 32'd1);
        if (mode == 0)
            check("start_to_done_edges", 32'(edges), 32'(2 * N + 2));
        if (mode == 1)
            check("stall_cycles", 32'(stall_cnt), 32'd3);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_fell",      32'(busy), 32'd0);
        check("done_pulses",    32'(done_cnt - done_before), 32'd1);
        exp_q.delete();
    endtask

    function automatic logic [31:0] rand_fp();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'h00000000;
        if (r == 1) return 32'h80000000;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    logic [31:0] vec [N];

    initial begin
        tests     = 0;
        fails     = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_idx",  32'(out_idx),   32'd0);
        check("reset_done",     32'(done),      32'd0);
        check("reset_sub_a",    sub_a,          32'd0);
        check("reset_sub_b",    sub_b,          32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic vector: 1, 3, 2.
        vec = '{32'h3F800000, 32'h40400000, 32'h40000000};
        send_vector(vec, 0, 1'b0);
        check("basic_max",  got_max,     32'h40400000);
        check("basic_d0",   got_data[0], 32'hC0000000);
        check("basic_d1",   got_data[1], 32'h00000000);
        check("basic_d2",   got_data[2], 32'hBF800000);

        // Negative inputs: -5, -1, -3.
        vec = '{32'hC0A00000, 32'hBF800000, 32'hC0400000};
        send_vector(vec, 0, 1'b0);
        check("neg_max", got_max,     32'hBF800000);
        check("neg_d0",  got_data[0], 32'hC0800000);
        check("neg_d1",  got_data[1], 32'h00000000);
        check("neg_d2",  got_data[2], 32'hC0000000);

        // Backpressure at index 1.
        vec = '{32'h3F800000, 32'h40400000, 32'h40000000};
        send_vector(vec, 1, 1'b0);
        check("bp_d0", got_data[0], 32'hC0000000);
        check("bp_d1", got_data[1], 32'h00000000);
        check("bp_d2", got_data[2], 32'hBF800000);

        // Tie between -0 (index 0) and +0 (index 2); start poked during SUB.
        vec = '{32'h80000000, 32'hBF800000, 32'h00000000};
        send_vector(vec, 0, 1'b1);
        check("tie_max", got_max,     32'h80000000);
        check("tie_d1",  got_data[1], 32'hBF800000);

        // Reset after one load beat.
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_max_out",  max_out,       32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec = '{32'h3F800000, 32'h40400000, 32'h40000000};
        send_vector(vec, 0, 1'b0);
        check("post_rst_d0", got_data[0], 32'hC0000000);

        // Clamp: 20.0 and zeros.
        vec = '{32'h41A00000, 32'h00000000, 32'h00000000};
        send_vector(vec, 0, 1'b0);
`ifdef SOFTMAX_SUB_CLAMP_EN
        check("clamp_d1", got_data[1], 32'hC1800000);
`else
        check("clamp_d1", got_data[1], 32'hC1A00000);
`endif

        // Randomized vectors with duplicated values, gaps and backpressure.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                vec[i] = rand_fp();
                if ((i > 0) && ($urandom_range(0, 4) == 0))
                    vec[i] = vec[$urandom_range(0, i - 1)];
            end
            send_vector(vec, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
